// File: rtl/riscv_pkg.sv
// Shared core types and constants: forwarding selects and hazard-unit payloads.
package riscv_pkg;

   localparam int unsigned REG_W = 5;

   // Forwarding unit operand selects
   localparam logic [1:0] FORWARD_NONE = 2'b00;
   localparam logic [1:0] FORWARD_MEM  = 2'b01;
   localparam logic [1:0] FORWARD_EX   = 2'b10;

   // Hazard unit enable / flush encodings
   localparam logic EN      = 1'b1;
   localparam logic STALL   = 1'b0;
   localparam logic FLUSH   = 1'b1;
   localparam logic NOFLUSH = 1'b0;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } HDU_state_t;

   typedef struct packed {
      logic [REG_W-1:0] id_rs1;
      logic [REG_W-1:0] id_rs2;
      logic             id_use_rs1;
      logic             id_use_rs2;
      logic [REG_W-1:0] ex_rd;
      logic             ex_memread;
      logic             ex_branch_taken;
      logic             mem_access;
   } HDU_data;

   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic idex_en;
      logic exmem_en;
      logic ifid_flush;
      logic idex_flush;
      logic memwb_bubble;
   } HDU_ctrl;

   // Load in EX whose destination is read by the instruction in ID
   function automatic logic load_use(input HDU_data d);
      return d.ex_memread && (d.ex_rd != '0) &&
             ((d.id_use_rs1 && (d.id_rs1 == d.ex_rd)) ||
              (d.id_use_rs2 && (d.id_rs2 == d.ex_rd)));
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
module sat_counter #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: hold at all-ones once saturated
   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1)) begin
         count_d = count_q + W'(1);
      end
   end

   // Count register
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/hazard_unit.sv
// Load-use / branch-squash / data-memory-wait hazard controller for the 5-stage core.
module hazard_unit
   import riscv_pkg::*;
#(
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       ID_rs1,
   input  logic [4:0]       ID_rs2,
   input  logic             ID_use_rs1,
   input  logic             ID_use_rs2,
   input  logic [4:0]       EX_rd,
   input  logic             EX_MemRead,
   input  logic             EX_branch_taken,
   input  logic             MEM_access,
   input  logic             dmem_ready,
   output logic             dmem_valid,
   output logic             PC_en,
   output logic             IFID_en,
   output logic             IDEX_en,
   output logic             EXMEM_en,
   output logic             IFID_flush,
   output logic             IDEX_flush,
   output logic             MEMWB_bubble,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

   HDU_state_t        state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              mem_err_q, mem_err_d;
   HDU_data           hd;
   HDU_ctrl           ctrl;
   logic              freeze;
   logic              dmem_valid_c;

   assign hd = '{
      id_rs1:          ID_rs1,
      id_rs2:          ID_rs2,
      id_use_rs1:      ID_use_rs1,
      id_use_rs2:      ID_use_rs2,
      ex_rd:           EX_rd,
      ex_memread:      EX_MemRead,
      ex_branch_taken: EX_branch_taken,
      mem_access:      MEM_access
   };

   // Next state, wait counter, and same-cycle pipeline control
   always_comb begin
      state_d      = state_q;
      wait_d       = wait_q;
      mem_err_d    = mem_err_q;
      freeze       = 1'b0;
      dmem_valid_c = 1'b0;
      ctrl         = '{pc_en: EN, ifid_en: EN, idex_en: EN, exmem_en: EN,
                       ifid_flush: NOFLUSH, idex_flush: NOFLUSH,
                       memwb_bubble: NOFLUSH};

      if (!rst) begin
         case (state_q)
            RUN: begin
               dmem_valid_c = hd.mem_access;
               if (hd.mem_access && !dmem_ready) begin
                  freeze  = 1'b1;
                  state_d = MEM_WAIT;
                  wait_d  = '0;
               end
            end
            MEM_WAIT: begin
               dmem_valid_c = 1'b1;
               freeze       = 1'b1;
               if (wait_q != WAIT_MAX) begin
                  wait_d = wait_q + WAIT_W'(1);
               end
               // Timeout only flags; the access is still waited out
               if (wait_d == WAIT_MAX) begin
                  mem_err_d = 1'b1;
               end
               if (dmem_ready) begin
                  state_d = RUN;
               end
            end
            default: begin
               state_d = RUN;
            end
         endcase

         if (freeze) begin
            ctrl.pc_en        = STALL;
            ctrl.ifid_en      = STALL;
            ctrl.idex_en      = STALL;
            ctrl.exmem_en     = STALL;
            ctrl.memwb_bubble = FLUSH;
         end else if (hd.ex_branch_taken) begin
            // Squashing ID also removes any load-use dependency
            ctrl.ifid_flush = FLUSH;
            ctrl.idex_flush = FLUSH;
         end else if (load_use(hd)) begin
            ctrl.pc_en      = STALL;
            ctrl.ifid_en    = STALL;
            ctrl.idex_flush = FLUSH;
         end
      end
   end

   // FSM state, wait counter and sticky error
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RUN;
         wait_q    <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         mem_err_q <= mem_err_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (!ctrl.pc_en),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (ctrl.ifid_flush),
      .count (flush_cnt)
   );

   assign dmem_valid   = dmem_valid_c;
   assign PC_en        = ctrl.pc_en;
   assign IFID_en      = ctrl.ifid_en;
   assign IDEX_en      = ctrl.idex_en;
   assign EXMEM_en     = ctrl.exmem_en;
   assign IFID_flush   = ctrl.ifid_flush;
   assign IDEX_flush   = ctrl.idex_flush;
   assign MEMWB_bubble = ctrl.memwb_bubble;
   assign mem_err      = mem_err_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with hand-computed expectations.
module tb_hazard_unit;

   logic        clk;
   logic        rst;
   logic [4:0]  ID_rs1, ID_rs2, EX_rd;
   logic        ID_use_rs1, ID_use_rs2;
   logic        EX_MemRead, EX_branch_taken, MEM_access, dmem_ready;
   logic        dmem_valid, PC_en, IFID_en, IDEX_en, EXMEM_en;
   logic        IFID_flush, IDEX_flush, MEMWB_bubble, mem_err;
   logic [31:0] stall_cnt, flush_cnt;

   int n_checks = 0;
   int n_errors = 0;

   hazard_unit #(.CNT_W(32), .MEM_TIMEOUT(16)) dut (
      .clk             (clk),
      .rst             (rst),
      .ID_rs1          (ID_rs1),
      .ID_rs2          (ID_rs2),
      .ID_use_rs1      (ID_use_rs1),
      .ID_use_rs2      (ID_use_rs2),
      .EX_rd           (EX_rd),
      .EX_MemRead      (EX_MemRead),
      .EX_branch_taken (EX_branch_taken),
      .MEM_access      (MEM_access),
      .dmem_ready      (dmem_ready),
      .dmem_valid      (dmem_valid),
      .PC_en           (PC_en),
      .IFID_en         (IFID_en),
      .IDEX_en         (IDEX_en),
      .EXMEM_en        (EXMEM_en),
      .IFID_flush      (IFID_flush),
      .IDEX_flush      (IDEX_flush),
      .MEMWB_bubble    (MEMWB_bubble),
      .mem_err         (mem_err),
      .stall_cnt       (stall_cnt),
      .flush_cnt       (flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ID_rs1 = '0; ID_rs2 = '0; EX_rd = '0;
      ID_use_rs1 = 1'b0; ID_use_rs2 = 1'b0;
      EX_MemRead = 1'b0; EX_branch_taken = 1'b0;
      MEM_access = 1'b0; dmem_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      tick();
      rst = 1'b0;
   endtask

   // Control vector packed as {PC,IFID,IDEX,EXMEM en, IFID,IDEX flush, bubble, dmem_valid}
   function automatic logic [31:0] ctl();
      return {24'd0, PC_en, IFID_en, IDEX_en, EXMEM_en,
              IFID_flush, IDEX_flush, MEMWB_bubble, dmem_valid};
   endfunction

   localparam logic [31:0] C_RUN      = 32'b1111_0000;
   localparam logic [31:0] C_LOADUSE  = 32'b0011_0100;
   localparam logic [31:0] C_BRANCH   = 32'b1111_1100;
   localparam logic [31:0] C_FREEZE   = 32'b0000_0011;
   localparam logic [31:0] C_RUN_MEM  = 32'b1111_0001;

   initial begin
      rst = 1'b1;
      idle();
      MEM_access = 1'b1;
      tick();
      #1;
      chk("reset_ctl", ctl(), C_RUN);
      chk("reset_stall", stall_cnt, 32'd0);
      chk("reset_flush", flush_cnt, 32'd0);
      chk("reset_err", 32'(mem_err), 32'd0);
      rst = 1'b0;
      idle();

      // Load-use on rs1
      EX_MemRead = 1'b1; EX_rd = 5'd5; ID_rs1 = 5'd5; ID_use_rs1 = 1'b1;
      #1 chk("lu_stall", ctl(), C_LOADUSE);
      tick();
      idle();
      #1 chk("lu_after", ctl(), C_RUN);
      chk("lu_stall_cnt", stall_cnt, 32'd1);

      // x0 destination never stalls
      EX_MemRead = 1'b1; EX_rd = 5'd0; ID_rs1 = 5'd0; ID_use_rs1 = 1'b1;
      #1 chk("lu_x0", ctl(), C_RUN);
      // Matching rs2 that is not actually read
      ID_use_rs1 = 1'b0; EX_rd = 5'd5; ID_rs2 = 5'd5; ID_use_rs2 = 1'b0;
      #1 chk("lu_rs2_unused", ctl(), C_RUN);
      ID_use_rs2 = 1'b1;
      #1 chk("lu_rs2_used", ctl(), C_LOADUSE);
      ID_use_rs2 = 1'b0;
      tick();
      chk("lu_cnt_hold", stall_cnt, 32'd1);

      // Branch beats load-use
      do_reset();
      EX_MemRead = 1'b1; EX_rd = 5'd7; ID_rs1 = 5'd7; ID_use_rs1 = 1'b1;
      EX_branch_taken = 1'b1;
      #1 chk("br_lu", ctl(), C_BRANCH);
      tick();
      idle();
      chk("br_flush_cnt", flush_cnt, 32'd1);
      chk("br_stall_cnt", stall_cnt, 32'd0);

      // Three wait cycles: four frozen cycles, branch held until afterwards
      do_reset();
      MEM_access = 1'b1; dmem_ready = 1'b0; EX_branch_taken = 1'b1;
      for (int i = 0; i < 4; i++) begin
         dmem_ready = (i == 3);
         #1 chk($sformatf("wait3_freeze%0d", i), ctl(), C_FREEZE);
         tick();
      end
      MEM_access = 1'b0; dmem_ready = 1'b0;
      #1 chk("wait3_branch", ctl(), C_BRANCH);
      chk("wait3_stall_cnt", stall_cnt, 32'd4);
      tick();
      chk("wait3_flush_cnt", flush_cnt, 32'd1);
      idle();
      // Zero-wait access: no stall
      MEM_access = 1'b1; dmem_ready = 1'b1;
      #1 chk("zero_wait", ctl(), C_RUN_MEM);
      tick();
      idle();
      #1 chk("zero_wait_next", ctl(), C_RUN);
      chk("zero_wait_cnt", stall_cnt, 32'd4);

      // Timeout: error after 16 completed MEM_WAIT cycles, sticky
      do_reset();
      MEM_access = 1'b1; dmem_ready = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         chk($sformatf("tmo_err%0d", i), 32'(mem_err), (i - 1 >= 16) ? 32'd1 : 32'd0);
         chk($sformatf("tmo_stall%0d", i), stall_cnt, 32'(i));
      end
      tick();
      dmem_ready = 1'b1;
      #1 chk("tmo_ready_freeze", ctl(), C_FREEZE);
      tick();
      idle();
      #1 chk("tmo_back_run", ctl(), C_RUN);
      chk("tmo_err_sticky", 32'(mem_err), 32'd1);
      tick();
      chk("tmo_err_sticky2", 32'(mem_err), 32'd1);
      rst = 1'b1;
      tick();
      chk("tmo_rst_err", 32'(mem_err), 32'd0);
      chk("tmo_rst_stall", stall_cnt, 32'd0);
      rst = 1'b0;

      // Reset during the second MEM_WAIT cycle abandons the access
      idle();
      MEM_access = 1'b1; dmem_ready = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1 chk("rst_wait_ctl", ctl(), C_RUN);
      tick();
      rst = 1'b0;
      chk("rst_wait_stall", stall_cnt, 32'd0);
      chk("rst_wait_err", 32'(mem_err), 32'd0);
      dmem_ready = 1'b1;
      #1 chk("rst_wait_state_run", ctl(), C_RUN_MEM);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard and stall controller for the 5-stage RISC-V core. It complements the forwarding unit. Forwarding resolves EX-stage operand dependencies by bypassing results. This block handles the cases bypassing cannot: load-use dependencies, taken-branch squashes, and multi-cycle data-memory accesses. It drives the PC and pipeline-register enables and flushes, runs the data-memory valid/ready handshake as initiator, and keeps stall/flush performance counters.

## Interface
Parameters:
- CNT_W, 32, width of each performance counter
- MEM_TIMEOUT, 16, maximum cycles in MEM_WAIT before the error flag is set (≥1)

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- ID_rs1, ID_rs2  in  5  source registers of the instruction in ID
- ID_use_rs1, ID_use_rs2  in  1  instruction in ID actually reads rs1 / rs2
- EX_rd  in  5  destination register of the instruction in EX
- EX_MemRead  in  1  instruction in EX is a load
- EX_branch_taken  in  1  branch/jump in EX resolved taken
- MEM_access  in  1  instruction in MEM is a load or store
- dmem_ready  in  1  data memory completes the access this cycle
- dmem_valid  out  1  request to data memory
- PC_en, IFID_en, IDEX_en, EXMEM_en  out  1  register enables (1 = advance)
- IFID_flush, IDEX_flush, MEMWB_bubble  out  1  insert NOP into that register
- mem_err  out  1  sticky; MEM_WAIT exceeded MEM_TIMEOUT
- stall_cnt, flush_cnt  out  CNT_W  performance counters

## Operation
- FSM states: RUN, MEM_WAIT.
- RUN:
  - dmem_valid = MEM_access.
  - MEM_access && !dmem_ready → freeze this cycle and go to MEM_WAIT next cycle.
- MEM_WAIT:
  - dmem_valid = 1 and freeze every cycle.
  - dmem_ready=1 → freeze is still applied that cycle; return to RUN next cycle.
- Freeze: PC_en = IFID_en = IDEX_en = EXMEM_en = 0, MEMWB_bubble = 1. All flushes are 0.
- load_use = EX_MemRead && EX_rd≠0 && ((ID_use_rs1 && ID_rs1==EX_rd) || (ID_use_rs2 && ID_rs2==EX_rd)).
- Priority:
  - Freeze wins over everything.
  - Otherwise EX_branch_taken: IFID_flush = IDEX_flush = 1, all enables 1.
  - Otherwise load_use: PC_en = IFID_en = 0, IDEX_flush = 1, others 1.
  - Otherwise all enables 1, all flushes and bubble 0.
- A taken branch during a freeze is not lost. EX is held, so EX_branch_taken persists and is applied in the first non-frozen cycle.
- A branch flush suppresses the load-use stall, because the dependent ID instruction is squashed.
- Wait counter: cleared on entering MEM_WAIT and incremented each MEM_WAIT cycle.
  - When it reaches MEM_TIMEOUT, mem_err is set and held until rst.
  - The FSM stays in MEM_WAIT; there is no abort.
- stall_cnt increments every cycle with PC_en=0 (freeze or load-use).
- flush_cnt increments every cycle with IFID_flush=1.
- Both counters saturate at 2^CNT_W−1.

## Timing
- All control outputs are combinational from state and current inputs: stalls and flushes take effect in the same cycle.
- State, wait counter, mem_err and the performance counters are registered.
- Reset values: state RUN, wait counter 0, mem_err 0, stall_cnt 0, flush_cnt 0.
- During rst=1:
  - dmem_valid = 0, all enables 1, all flushes and bubble 0.
  - rst asserted in MEM_WAIT abandons the access; dmem_valid drops in that cycle.
- Zero-wait access (MEM_access with dmem_ready=1 in RUN) causes no stall.
- An access with k wait cycles (ready arrives k cycles after the first request cycle) freezes the pipeline for k+1 cycles.
- Load-use costs exactly 1 stall cycle. Next cycle the load is in MEM, so load_use is no longer true.

## Structure
- riscv_pkg additions:
  - HDU_state_t enum {RUN, MEM_WAIT}
  - HDU_data struct (ID/EX/MEM hazard inputs)
  - HDU_ctrl struct (enables/flushes)
  - EN/STALL and FLUSH/NOFLUSH constants next to the existing FORWARD_* constants
- Sub-module sat_counter (parameter W; inputs clk, rst, inc; output count) is instantiated twice for the performance counters.

## Test plan
- Load x5 in EX, ID reads rs1=x5 → one cycle of PC_en=0, IFID_en=0, IDEX_flush=1. Next cycle all enables 1; stall_cnt=1.
- Load with EX_rd=0, ID_rs1=0 → no stall. Also ID_rs2=x5 with ID_use_rs2=0 → no stall.
- EX_branch_taken=1 and load_use=1 in the same cycle → IFID_flush=IDEX_flush=1, PC_en=1; flush_cnt=1, stall_cnt=0.
- MEM_access with dmem_ready low for 3 cycles then high → freeze for 4 cycles, MEMWB_bubble=1, dmem_valid=1 throughout; RUN afterwards; stall_cnt=4.
- MEM_access, dmem_ready held low for 20 cycles with MEM_TIMEOUT=16 → mem_err rises after 16 MEM_WAIT cycles and stays 1 after ready. rst clears it and the counters.
- rst asserted in the 2nd MEM_WAIT cycle → dmem_valid=0 that cycle, state RUN, counters 0 next cycle.
